// File: rtl/rob_ins_arbiter.sv
// rob_ins_arbiter
// Round-robin arbiter that shares the single ROB insert port among several
// completing requesters. One winner's sequence number and payload are latched,
// ins_en is held until the ROB answers with ins_cpl, and the winner then gets
// a one-cycle req_rdy pulse. A watchdog abandons inserts that never complete
// and raises a sticky error flag.
module rob_ins_arbiter #(
    parameter int p_num_req  = 4,
    parameter int p_depth    = 32,
    parameter int p_ptrwidth = $clog2(p_depth),
    parameter int p_bitwidth = 32,
    parameter int p_timeout  = 64
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [p_num_req-1:0]              req_val,
    input  logic [p_num_req*p_ptrwidth-1:0]   req_sn,
    input  logic [p_num_req*p_bitwidth-1:0]   req_data,
    output logic [p_num_req-1:0]              req_rdy,
    output logic                              ins_en,
    output logic [p_ptrwidth-1:0]             ins_sn_in,
    output logic [p_bitwidth-1:0]             ins_data_in,
    input  logic                              ins_cpl,
    output logic                              busy,
    output logic [$clog2(p_num_req)-1:0]      grant_id,
    output logic                              timeout_err
);

    localparam int LP_GW = $clog2(p_num_req);
    localparam int LP_CW = $clog2(p_timeout + 1);
    localparam logic [LP_GW-1:0] LP_LAST_ID = LP_GW'(p_num_req - 1);
    localparam logic [LP_CW-1:0] LP_CNT_END = LP_CW'(p_timeout - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    // Registered state and outputs
    state_t                  r_state;
    logic                    r_ins_en;
    logic [p_ptrwidth-1:0]   r_sn;
    logic [p_bitwidth-1:0]   r_data;
    logic [p_num_req-1:0]    r_rdy;
    logic [LP_GW-1:0]        r_grant;
    logic [LP_GW-1:0]        r_rr_ptr;
    logic [LP_CW-1:0]        r_cnt;
    logic                    r_err;

    // Next-state values
    state_t                  w_state_next;
    logic                    w_ins_en_next;
    logic [p_ptrwidth-1:0]   w_sn_next;
    logic [p_bitwidth-1:0]   w_data_next;
    logic [p_num_req-1:0]    w_rdy_next;
    logic [LP_GW-1:0]        w_grant_next;
    logic [LP_GW-1:0]        w_rr_ptr_next;
    logic [LP_CW-1:0]        w_cnt_next;
    logic                    w_err_next;

    // Arbitration helpers
    logic [p_num_req-1:0]    w_hi_req;
    logic [p_num_req-1:0]    w_grant_onehot;
    logic                    w_hi_found;
    logic [LP_GW-1:0]        w_hi_idx;
    logic [LP_GW-1:0]        w_all_idx;
    logic [LP_GW-1:0]        w_sel;
    logic                    w_any;
    logic [LP_GW-1:0]        w_rr_adv;
    logic [p_ptrwidth-1:0]   w_sn_lane   [p_num_req];
    logic [p_bitwidth-1:0]   w_data_lane [p_num_req];

    // Per-lane unpacking, the "at or above rr_ptr" request mask, and the
    // one-hot acknowledge vector for the current winner.
    genvar gi;
    generate
        for (gi = 0; gi < p_num_req; gi++) begin : g_lane
            localparam logic [LP_GW-1:0] LP_IDX = LP_GW'(gi);
            assign w_sn_lane[gi]      = req_sn[gi*p_ptrwidth +: p_ptrwidth];
            assign w_data_lane[gi]    = req_data[gi*p_bitwidth +: p_bitwidth];
            assign w_hi_req[gi]       = req_val[gi] && (LP_IDX >= r_rr_ptr);
            assign w_grant_onehot[gi] = (r_grant == LP_IDX);
        end
    endgenerate

    // Wrapping search: the lowest request at or above rr_ptr wins, otherwise
    // the lowest request overall (the wrapped-around part of the ring).
    always_comb begin
        w_hi_found = 1'b0;
        w_hi_idx   = '0;
        w_all_idx  = '0;
        for (int i = p_num_req - 1; i >= 0; i--) begin
            if (w_hi_req[i]) begin
                w_hi_found = 1'b1;
                w_hi_idx   = LP_GW'(i);
            end
            if (req_val[i]) begin
                w_all_idx = LP_GW'(i);
            end
        end
    end

    assign w_sel    = w_hi_found ? w_hi_idx : w_all_idx;
    assign w_any    = |req_val;
    assign w_rr_adv = (r_grant == LP_LAST_ID) ? '0 : r_grant + LP_GW'(1);

    // Next-state and next-output logic for the IDLE/ISSUE/RELEASE sequence
    always_comb begin
        w_state_next  = r_state;
        w_ins_en_next = r_ins_en;
        w_sn_next     = r_sn;
        w_data_next   = r_data;
        w_rdy_next    = '0;
        w_grant_next  = r_grant;
        w_rr_ptr_next = r_rr_ptr;
        w_cnt_next    = r_cnt;
        w_err_next    = r_err;
        case (r_state)
            ST_IDLE: begin
                w_ins_en_next = 1'b0;
                if (w_any) begin
                    w_sn_next     = w_sn_lane[w_sel];
                    w_data_next   = w_data_lane[w_sel];
                    w_grant_next  = w_sel;
                    w_ins_en_next = 1'b1;
                    w_cnt_next    = '0;
                    w_state_next  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (ins_cpl) begin
                    // Completion takes priority over a coincident timeout.
                    w_ins_en_next = 1'b0;
                    w_rdy_next    = w_grant_onehot;
                    w_rr_ptr_next = w_rr_adv;
                    w_state_next  = ST_RELEASE;
                end else if (r_cnt == LP_CNT_END) begin
                    // This edge is the p_timeout-th ISSUE cycle: give up.
                    w_ins_en_next = 1'b0;
                    w_err_next    = 1'b1;
                    w_rr_ptr_next = w_rr_adv;
                    w_state_next  = ST_RELEASE;
                end else begin
                    w_cnt_next = r_cnt + LP_CW'(1);
                end
            end
            ST_RELEASE: begin
                w_ins_en_next = 1'b0;
                w_state_next  = ST_IDLE;
            end
            default: begin
                w_ins_en_next = 1'b0;
                w_state_next  = ST_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_ins_en <= 1'b0;
            r_sn     <= '0;
            r_data   <= '0;
            r_rdy    <= '0;
            r_grant  <= '0;
            r_rr_ptr <= '0;
            r_cnt    <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_ins_en <= w_ins_en_next;
            r_sn     <= w_sn_next;
            r_data   <= w_data_next;
            r_rdy    <= w_rdy_next;
            r_grant  <= w_grant_next;
            r_rr_ptr <= w_rr_ptr_next;
            r_cnt    <= w_cnt_next;
            r_err    <= w_err_next;
        end
    end

    assign ins_en      = r_ins_en;
    assign ins_sn_in   = r_sn;
    assign ins_data_in = r_data;
    assign req_rdy     = r_rdy;
    assign grant_id    = r_grant;
    assign timeout_err = r_err;
    assign busy        = (r_state != ST_IDLE);

endmodule
